if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage directly upstream of id_stage. It owns the program counter, issues single-outstanding word fetches to program memory over a req/gnt/rvalid handshake, and drives the IF/ID pipeline register (d_instruction_o, d_pc_o, d_pc4_o). It honours id_stage's stall and branch/jump redirect (stall_o, brj_o, brj_pc_o). Bubbles are inserted as NOP.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, instruction injected on bubble/flush (addi x0,x0,0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  from id_stage stall_o; hold IF/ID register and PC
brj_i  in  1  from id_stage brj_o; redirect fetch
brj_pc_i  in  `DATA_WIDTH  redirect target (id_stage brj_pc_o)
instr_req_o  out  1  fetch request
instr_addr_o  out  `DATA_WIDTH  fetch address, word aligned
instr_gnt_i  in  1  request accepted this cycle
instr_rvalid_i  in  1  read data valid (one or more cycles after gnt)
instr_rdata_i  in  `DATA_WIDTH  fetched instruction
d_instruction_o  out  `DATA_WIDTH  to id_stage d_instruction_i
d_pc_o  out  `DATA_WIDTH  PC of d_instruction_o
d_pc4_o  out  `DATA_WIDTH  d_pc_o + 4
fetch_misalign_o  out  1  present only with IF_MISALIGN_CHECK_EN

Behaviour:
- Reset: pc_q=BOOT_ADDR, state=F_IDLE, kill=0, skid empty, d_instruction_o=NOP_INSTR, d_pc_o=0, d_pc4_o=0, instr_req_o=0, fetch_misalign_o=0.
- instr_addr_o = pc_q always. Addresses are word aligned; pc arithmetic mod 2^32 (0xFFFF_FFFC+4 wraps to 0).
- FSM:
  F_IDLE: one cycle after reset release -> F_REQ.
  F_REQ: instr_req_o=1 if skid empty. On gnt: fetch_pc<=pc_q, pc_q<=pc_q+4, -> F_WAIT.
  F_WAIT: instr_req_o=0 except back-to-back case below. On rvalid: kill=1 -> discard data, clear kill; else deliver (see IF/ID rule). Next F_REQ, or F_FULL if data went to skid.
  F_FULL: skid holds one instruction; no request. On stall_i=0 -> F_REQ.
- Back-to-back: in F_WAIT, when rvalid_i=1, kill=0, stall_i=0, brj_i=0, instr_req_o asserts same cycle for pc_q; with gnt stay in F_WAIT. Zero-wait memory (gnt=1, rvalid 1 cycle later) yields 1 instruction/cycle.
- IF/ID register, per clock edge:
  stall_i=1: hold all d_* outputs; rvalid data (not killed) goes to skid.
  stall_i=0 & brj_i=1: load NOP_INSTR (flush), clear skid.
  stall_i=0 & skid valid: load skid entry, clear skid.
  stall_i=0 & rvalid & !kill: load instr_rdata_i, d_pc_o=fetch_pc, d_pc4_o=fetch_pc+4.
  otherwise: load NOP_INSTR, d_pc_o/d_pc4_o unchanged.
- Redirect: brj_i is honoured only when stall_i=0. pc_q<=brj_pc_i with bits[1:0] cleared. If a request is outstanding (F_WAIT, or F_REQ with gnt same cycle), kill<=1 and its response is discarded. State -> F_WAIT (kill set) or F_REQ. Redirect has priority over skid and rvalid.
- Simultaneous rvalid and brj_i: the returning data is dropped; the flush NOP is loaded.
- Asynchronous reset mid-transaction: everything returns to reset values immediately. A later rvalid for the pre-reset request is ignored in F_IDLE/F_REQ.

Optional Feature:
IF_MISALIGN_CHECK_EN: adds fetch_misalign_o. It pulses high for one cycle (registered) when an honoured redirect has brj_pc_i[1:0]!=0; the target is still aligned by clearing bits[1:0]. Without the macro the port is absent and misaligned targets are aligned silently.

Test Plan:
- Reset release, BOOT_ADDR=0, zero-wait memory returning addr as data -> first d_pc_o=0 three edges after release, then d_pc_o 4,8,12 on consecutive cycles; d_pc4_o=d_pc_o+4.
- stall_i held 3 cycles mid-stream with one response in flight -> d_* frozen, no instr_req_o while skid full, skid instruction delivered on first unstalled edge, no loss or duplication.
- brj_i=1, brj_pc_i=0x100 while request outstanding -> that response is dropped, d_instruction_o=0x13 for one cycle, next delivered d_pc_o=0x100.
- gnt withheld 2 cycles, rvalid 3 cycles late -> NOPs delivered meanwhile, correct PC sequence resumes.
- pc_q at 0xFFFF_FFFC -> next fetch address 0x0000_0000.
- With IF_MISALIGN_CHECK_EN, brj_pc_i=0x102 -> fetch_misalign_o=1 for one cycle, instr_addr_o=0x100.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and drives the IF/ID register.
// Optional IF_MISALIGN_CHECK_EN adds fetch_misalign_o, a one-cycle flag for a misaligned redirect target.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_stage #(
  parameter logic [`DATA_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [`DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   brj_i,
  input  logic [`DATA_WIDTH-1:0] brj_pc_i,
  output logic                   instr_req_o,
  output logic [`DATA_WIDTH-1:0] instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [`DATA_WIDTH-1:0] instr_rdata_i,
  output logic [`DATA_WIDTH-1:0] d_instruction_o,
  output logic [`DATA_WIDTH-1:0] d_pc_o,
  output logic [`DATA_WIDTH-1:0] d_pc4_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                   fetch_misalign_o
`endif
);

  localparam int W = `DATA_WIDTH;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_FULL} state_e;

  state_e         state_q;
  logic [W-1:0]   pc_q;
  logic [W-1:0]   fetch_pc_q;
  logic           kill_q;
  logic           skid_valid_q;
  logic [W-1:0]   skid_instr_q;
  logic [W-1:0]   skid_pc_q;

  logic           redirect;
  logic           deliver;
  logic           accept;
  logic [W-1:0]   brj_target;

  // A redirect only counts when id_stage is not stalled; deliver means a live (unkilled) response.
  assign redirect     = brj_i & ~stall_i;
  assign deliver      = (state_q == F_WAIT) & instr_rvalid_i & ~kill_q;
  assign brj_target   = brj_pc_i & ~W'(3);
  assign instr_addr_o = pc_q;

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    instr_req_o = 1'b0;
    unique case (state_q)
      F_REQ:   instr_req_o = ~skid_valid_q;
      F_WAIT:  instr_req_o = deliver & ~stall_i & ~brj_i;
      default: instr_req_o = 1'b0;
    endcase
  end

  assign accept = instr_req_o & instr_gnt_i;

  // PC, fetch FSM and kill flag for a response that a redirect made stale.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (!rst_n) begin
      state_q    <= F_IDLE;
      pc_q       <= BOOT_ADDR;
      fetch_pc_q <= BOOT_ADDR;
      kill_q     <= 1'b0;
    end else begin
      if (accept) begin
        fetch_pc_q <= pc_q;
        pc_q       <= pc_q + W'(4);
      end
      if (redirect) pc_q <= brj_target;

      case (state_q)
        F_IDLE: state_q <= F_REQ;
        F_REQ: begin
          if (accept) begin
            state_q <= F_WAIT;
            kill_q  <= redirect;
          end
        end
        F_WAIT: begin
          if (instr_rvalid_i) begin
            kill_q <= 1'b0;
            if (deliver && stall_i) state_q <= F_FULL;
            else if (accept)        state_q <= F_WAIT;
            else                    state_q <= F_REQ;
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        F_FULL:  if (!stall_i) state_q <= F_REQ;
        default: state_q <= F_IDLE;
      endcase
    end
  end

  // IF/ID register plus one-entry skid for a response that lands while id_stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_instruction_o <= NOP_INSTR;
      d_pc_o          <= '0;
      d_pc4_o         <= '0;
      skid_valid_q    <= 1'b0;
      skid_instr_q    <= NOP_INSTR;
      skid_pc_q       <= '0;
    end else if (stall_i) begin
      if (deliver) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= instr_rdata_i;
        skid_pc_q    <= fetch_pc_q;
      end
    end else if (brj_i) begin
      d_instruction_o <= NOP_INSTR;
      skid_valid_q    <= 1'b0;
    end else if (skid_valid_q) begin
      d_instruction_o <= skid_instr_q;
      d_pc_o          <= skid_pc_q;
      d_pc4_o         <= skid_pc_q + W'(4);
      skid_valid_q    <= 1'b0;
    end else if (deliver) begin
      d_instruction_o <= instr_rdata_i;
      d_pc_o          <= fetch_pc_q;
      d_pc4_o         <= fetch_pc_q + W'(4);
    end else begin
      d_instruction_o <= NOP_INSTR;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_misalign_o <= 1'b0;
    else        fetch_misalign_o <= redirect & (|brj_pc_i[1:0]);
  end
`endif

endmodule
